// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: frame sequencer ahead of spi_physical with TX/RX byte FIFOs and status flags
module spi_xfer_ctrl #(
    parameter int DEPTH = 16,
    parameter int LEN_W = 8,
    parameter logic [7:0] FILL = 8'hFF,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [LEN_W-1:0] xfer_len,
    input  logic             tx_en,
    input  logic             rx_en,
    input  logic             tx_wr,
    input  logic [7:0]       tx_data,
    input  logic             rx_rd,
    output logic [7:0]       rx_data,
    output logic             tx_full,
    output logic             rx_empty,
    output logic [AW:0]      tx_level,
    output logic [AW:0]      rx_level,
    output logic             busy,
    output logic             done,
    output logic             err_underrun,
    output logic             err_overrun,
    output logic             phy_ena,
    output logic [7:0]       phy_data_in,
    input  logic             phy_new_byte,
    input  logic [7:0]       phy_data_out,
    input  logic             phy_idle
);
    localparam logic [1:0] IDLE = 2'd0, XFER = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    logic [1:0] state;
    logic [LEN_W-1:0] rem;
    logic tx_en_l, rx_en_l;
    logic [7:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic tx_empty, rx_full, accept, byte_done, tx_push, tx_pop, rx_push, rx_pop, rx_lost, underrun;
    // FIFO flags, handshake decode and phy-facing outputs
    always_comb begin
        tx_empty = tx_level == '0;
        tx_full = tx_level == FULL_LVL;
        rx_empty = rx_level == '0;
        rx_full = rx_level == FULL_LVL;
        accept = state == IDLE && start && xfer_len != '0 && phy_idle;
        byte_done = state == XFER && phy_new_byte && rem != '0;
        tx_push = tx_wr && !tx_full;
        tx_pop = byte_done && tx_en_l && !tx_empty;
        rx_push = byte_done && rx_en_l && !rx_full;
        rx_lost = byte_done && rx_en_l && rx_full;
        rx_pop = rx_rd && !rx_empty;
        underrun = state == XFER && !phy_new_byte && tx_en_l && tx_empty && rem != '0;
        phy_ena = state == XFER && rem != '0 && (!tx_en_l || !tx_empty);
        phy_data_in = state != XFER ? 8'h00 : !tx_en_l ? FILL : tx_empty ? 8'h00 : tx_mem[tx_rp];
        rx_data = rx_empty ? 8'h00 : rx_mem[rx_rp];
        busy = state != IDLE;
        done = state == DONE;
    end
    // Frame sequencer: count bytes down, abort on underrun, wait for chip-select release
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state <= IDLE;
            rem <= '0;
            tx_en_l <= 1'b0;
            rx_en_l <= 1'b0;
        end else if (accept) begin
            state <= XFER;
            rem <= xfer_len;
            tx_en_l <= tx_en;
            rx_en_l <= rx_en;
        end else if (byte_done) begin
            rem <= rem - 1'b1;
            state <= rem == LEN_W'(1) ? DRAIN : XFER;
        end else if (underrun) begin
            state <= DRAIN;
        end else if (state == DRAIN && phy_idle) begin
            state <= DONE;
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
    // Sticky error flags, cleared when a new frame is accepted
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            err_underrun <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_underrun <= (!accept && err_underrun) || underrun;
            err_overrun <= (!accept && err_overrun) || rx_lost || (tx_wr && tx_full);
        end
    end
    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            tx_wp <= '0;
            tx_rp <= '0;
            tx_level <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
            rx_level <= '0;
        end else begin
            tx_wp <= tx_wp + AW'(tx_push);
            tx_rp <= tx_rp + AW'(tx_pop);
            tx_level <= tx_level + (AW + 1)'(tx_push) - (AW + 1)'(tx_pop);
            rx_wp <= rx_wp + AW'(rx_push);
            rx_rp <= rx_rp + AW'(rx_pop);
            rx_level <= rx_level + (AW + 1)'(rx_push) - (AW + 1)'(rx_pop);
        end
    end
    // FIFO storage
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= tx_data;
        if (rx_push) rx_mem[rx_wp] <= phy_data_out;
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed checks of spi_xfer_ctrl against a behavioural spi_physical stand-in
`timescale 1ns/1ps
module tb_spi_xfer_ctrl;
    logic clk = 1'b0;
    logic nrst = 1'b1;
    logic start = 1'b0, tx_en = 1'b0, rx_en = 1'b0, tx_wr = 1'b0, rx_rd = 1'b0;
    logic [7:0] xfer_len = 8'd0, tx_data = 8'd0;
    logic [7:0] rx_data, phy_data_in;
    logic tx_full, rx_empty, busy, done, err_underrun, err_overrun, phy_ena;
    logic [4:0] tx_level, rx_level;
    logic phy_new_byte = 1'b0, phy_idle = 1'b1;
    logic [7:0] phy_data_out = 8'h00;
    logic [7:0] mosi[$];
    logic [7:0] resp[$];
    logic [7:0] cur = 8'h00;
    int sh = 0, quiet = 0;
    int n_chk = 0, n_fail = 0, d = 0;

    spi_xfer_ctrl dut (
        .clk(clk), .nrst(nrst), .start(start), .xfer_len(xfer_len), .tx_en(tx_en), .rx_en(rx_en),
        .tx_wr(tx_wr), .tx_data(tx_data), .rx_rd(rx_rd), .rx_data(rx_data), .tx_full(tx_full),
        .rx_empty(rx_empty), .tx_level(tx_level), .rx_level(rx_level), .busy(busy), .done(done),
        .err_underrun(err_underrun), .err_overrun(err_overrun), .phy_ena(phy_ena),
        .phy_data_in(phy_data_in), .phy_new_byte(phy_new_byte), .phy_data_out(phy_data_out),
        .phy_idle(phy_idle)
    );

    always #5 clk = ~clk;

    // Phy stand-in: takes a byte while ena is high, shifts 4 cycles, pulses new_byte,
    // holds idle low 3 cycles after activity; returns resp bytes or loops MOSI back
    always @(negedge clk or posedge nrst) begin
        if (nrst) begin
            sh = 0;
            quiet = 0;
            phy_new_byte = 1'b0;
            phy_idle = 1'b1;
        end else begin
            phy_new_byte = 1'b0;
            if (sh != 0) begin
                sh--;
                if (sh == 0) begin
                    phy_new_byte = 1'b1;
                    phy_data_out = resp.size() != 0 ? resp.pop_front() : cur;
                end
            end else if (phy_ena) begin
                cur = phy_data_in;
                mosi.push_back(cur);
                sh = 4;
            end
            quiet = (sh != 0 || phy_new_byte) ? 3 : (quiet > 0 ? quiet - 1 : 0);
            phy_idle = quiet == 0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        tx_data = b;
        tx_wr = 1'b1;
        tick;
        tx_wr = 1'b0;
    endtask

    task automatic go(input logic [7:0] len, input logic t, input logic r);
        xfer_len = len;
        tx_en = t;
        rx_en = r;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, rx_data, exp);
        rx_rd = 1'b1;
        tick;
        rx_rd = 1'b0;
    endtask

    task automatic run(output int dn);
        dn = 0;
        for (int i = 0; i < 400; i++) begin
            tick;
            if (done) dn++;
            if (!busy) return;
        end
        chk("timeout_busy", busy, 0);
    endtask

    initial begin
        tick;
        tick;
        nrst = 1'b0;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_phy_ena", phy_ena, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_errs", {err_underrun, err_overrun, tx_full}, 0);
        chk("rst_phy_data_in", phy_data_in, 0);

        push(8'hA5);
        push(8'h3C);
        chk("t1_tx_level", tx_level, 2);
        go(8'd2, 1'b1, 1'b1);
        chk("t1_ena_latency", phy_ena, 1);
        chk("t1_busy", busy, 1);
        chk("t1_data_in", phy_data_in, 8'hA5);
        run(d);
        chk("t1_done_pulses", d, 1);
        chk("t1_mosi_n", mosi.size(), 2);
        if (mosi.size() == 2) begin
            chk("t1_mosi0", mosi[0], 8'hA5);
            chk("t1_mosi1", mosi[1], 8'h3C);
        end
        chk("t1_rx_level", rx_level, 2);
        chk("t1_errs", {err_underrun, err_overrun}, 0);
        pop_chk("t1_rx0", 8'hA5);
        pop_chk("t1_rx1", 8'h3C);
        chk("t1_rx_empty", rx_empty, 1);

        mosi.delete();
        resp.push_back(8'h11);
        resp.push_back(8'h22);
        resp.push_back(8'h33);
        go(8'd3, 1'b0, 1'b1);
        chk("t2_data_in_fill", phy_data_in, 8'hFF);
        run(d);
        chk("t2_done_pulses", d, 1);
        chk("t2_mosi_n", mosi.size(), 3);
        if (mosi.size() == 3) chk("t2_mosi_all", {mosi[0], mosi[1], mosi[2]}, 24'hFFFFFF);
        chk("t2_tx_level", tx_level, 0);
        pop_chk("t2_rx0", 8'h11);
        pop_chk("t2_rx1", 8'h22);
        pop_chk("t2_rx2", 8'h33);

        mosi.delete();
        push(8'h55);
        go(8'd3, 1'b1, 1'b0);
        run(d);
        chk("t3_done_pulses", d, 1);
        chk("t3_mosi_n", mosi.size(), 1);
        if (mosi.size() == 1) chk("t3_mosi0", mosi[0], 8'h55);
        chk("t3_underrun", err_underrun, 1);
        chk("t3_overrun", err_overrun, 0);
        chk("t3_rx_level", rx_level, 0);

        mosi.delete();
        for (int i = 0; i < 17; i++) push(8'(i));
        chk("t4_tx_level_full", tx_level, 16);
        chk("t4_tx_full", tx_full, 1);
        chk("t4_tx_overrun", err_overrun, 1);
        go(8'd17, 1'b1, 1'b1);
        chk("t4_err_cleared", {err_underrun, err_overrun}, 0);
        for (int i = 0; i < 100 && tx_level == 5'd16; i++) tick;
        chk("t4_first_pop", tx_level, 15);
        push(8'h10);
        run(d);
        chk("t4_done_pulses", d, 1);
        chk("t4_mosi_n", mosi.size(), 17);
        if (mosi.size() == 17) chk("t4_mosi16", mosi[16], 8'h10);
        chk("t4_rx_level", rx_level, 16);
        chk("t4_rx_overrun", err_overrun, 1);
        chk("t4_underrun", err_underrun, 0);
        chk("t4_rx_head", rx_data, 8'h00);
        rx_rd = 1'b1;
        for (int i = 0; i < 16; i++) tick;
        rx_rd = 1'b0;
        chk("t4_rx_drained", {rx_empty, rx_level}, {1'b1, 5'd0});

        mosi.delete();
        go(8'd0, 1'b1, 1'b0);
        chk("t5_len0_busy", busy, 0);
        tick;
        chk("t5_len0_done", done, 0);
        push(8'h01);
        push(8'h02);
        go(8'd2, 1'b1, 1'b0);
        go(8'd5, 1'b0, 1'b1);
        chk("t5_busy_held", busy, 1);
        run(d);
        chk("t5_done_pulses", d, 1);
        chk("t5_mosi_n", mosi.size(), 2);
        chk("t5_rx_level", rx_level, 0);

        mosi.delete();
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
        go(8'd5, 1'b1, 1'b1);
        for (int i = 0; i < 200 && rx_level != 5'd2; i++) tick;
        chk("t6_two_bytes", rx_level, 2);
        nrst = 1'b1;
        #1;
        chk("t6_rst_ena", phy_ena, 0);
        chk("t6_rst_levels", {tx_level, rx_level}, 0);
        chk("t6_rst_busy", busy, 0);
        d = 0;
        tick;
        if (done) d++;
        nrst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (done) d++;
        end
        chk("t6_no_done", d, 0);
        mosi.delete();
        push(8'h77);
        push(8'h88);
        go(8'd2, 1'b1, 1'b1);
        run(d);
        chk("t6_done_pulses", d, 1);
        chk("t6_mosi_n", mosi.size(), 2);
        pop_chk("t6_rx0", 8'h77);
        pop_chk("t6_rx1", 8'h88);
        chk("t6_errs", {err_underrun, err_overrun}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
